stopwatch_engine: RTL and testbench

//  Parametrised stopwatch/timer core: tick prescaler, N-digit mixed-radix BCD counter chain, run/pause/clear/lap control FSM.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/bcd_digit_counter.sv | 38 +++
 rtl/stopwatch_engine.sv | 155 +++++++++++++++
 tb/tb_stopwatch_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch engine: FSM state encoding, digit width
// and the per-digit base lookup used to size each BCD counter.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Base of digit i from the packed 4-bit-per-digit table (digit0 in [3:0]).
    function automatic int digit_base(input logic [31:0] bases, input int i);
        return int'(bases[i*DIGIT_W +: DIGIT_W]);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One digit of the mixed-radix chain: counts 0..BASE-1 up or down, with a
// clamped parallel load and a terminal flag that feeds the carry/borrow chain.
module bcd_digit_counter #(
    parameter int BASE = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       dn,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       at_term
);

    localparam logic [3:0] MAX = 4'(BASE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= (d > MAX) ? MAX : d;
        end else if (en) begin
            if (dn) begin
                q <= (q == 4'd0) ? MAX : q - 4'd1;
            end else begin
                q <= (q == MAX) ? 4'd0 : q + 4'd1;
            end
        end
    end

    assign at_term = dn ? (q == 4'd0) : (q == MAX);

endmodule

// File: rtl/stopwatch_engine.sv
// Stopwatch/timer core: tick prescaler, mixed-radix BCD chain and run/pause/
// clear/lap control. Define STOPWATCH_COUNTDOWN_EN to add load and count-down.
module stopwatch_engine
    import stopwatch_pkg::*;
#(
    parameter int          CLK_FREQ_HZ  = 100_000_000,
    parameter int          TICK_FREQ_HZ = 1,
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] DIGIT_BASES  = 32'h0000_6A6A
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_stop,
    input  logic                          clear,
    input  logic                          lap,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic                          count_down,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    output logic                          done,
`endif
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits_out,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow,
    output logic                          tick
);

    localparam int              PRESCALE = CLK_FREQ_HZ / TICK_FREQ_HZ;
    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_TC    = PS_W'(PRESCALE - 1);
    localparam int              DW       = DIGIT_W * NUM_DIGITS;

    if (CLK_FREQ_HZ % TICK_FREQ_HZ != 0) begin : g_bad_freq
        $error("stopwatch_engine: CLK_FREQ_HZ must be a multiple of TICK_FREQ_HZ");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("stopwatch_engine: NUM_DIGITS must be 1..8");
    end

    logic [1:0]            state, state_next;
    logic [PS_W-1:0]       prescaler;
    logic [DW-1:0]         live, snapshot, load_val;
    logic [NUM_DIGITS-1:0] at_term, digit_en;
    logic [NUM_DIGITS:0]   carry;
    logic                  step, chain_full, wrap, finish, cnt_dn, load_go, lap_ok;

`ifdef STOPWATCH_COUNTDOWN_EN
    assign cnt_dn   = count_down;
    assign load_go  = load && !clear && (state == ST_IDLE || state == ST_PAUSE);
    assign load_val = load_value;
`else
    assign cnt_dn   = 1'b0;
    assign load_go  = 1'b0;
    assign load_val = '0;
`endif

    // A coincident clear suppresses the tick so it cannot advance the chain.
    assign step       = (state == ST_RUN) && (prescaler == PS_TC) && !clear;
    assign tick       = step;
    assign carry[0]   = step;
    assign chain_full = carry[NUM_DIGITS];
    assign wrap       = chain_full && !cnt_dn;
    assign finish     = chain_full && cnt_dn;
    assign lap_ok     = lap && !clear && !start_stop && !load_go;
    assign running    = (state == ST_RUN);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (digit_base(DIGIT_BASES, i) < 2 || digit_base(DIGIT_BASES, i) > 10) begin : g_bad_base
            $error("stopwatch_engine: each digit base must be 2..10");
        end

        bcd_digit_counter #(
            .BASE(digit_base(DIGIT_BASES, i))
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clear),
            .en     (digit_en[i]),
            .dn     (cnt_dn),
            .load   (load_go),
            .d      (load_val[i*DIGIT_W +: DIGIT_W]),
            .q      (live[i*DIGIT_W +: DIGIT_W]),
            .at_term(at_term[i])
        );

        assign carry[i+1]  = carry[i] & at_term[i];
        // Counting down from all-zero must hold at zero instead of borrowing.
        assign digit_en[i] = carry[i] & ~finish;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (clear || finish) begin
            state_next = ST_IDLE;
        end else if (load_go) begin
            state_next = state;
        end else if (start_stop) begin
            case (state)
                ST_IDLE, ST_PAUSE: state_next = ST_RUN;
                ST_RUN:            state_next = ST_PAUSE;
                default:           state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: the snapshot is a plain register bank, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prescaler  <= '0;
            overflow   <= 1'b0;
            lap_active <= 1'b0;
            snapshot   <= '0;
            digits_out <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                prescaler  <= '0;
                overflow   <= 1'b0;
                lap_active <= 1'b0;
                snapshot   <= '0;
                digits_out <= '0;
            end else begin
                if (state == ST_RUN) begin
                    prescaler <= (prescaler == PS_TC) ? '0 : prescaler + 1'b1;
                end
                if (wrap) begin
                    overflow <= 1'b1;
                end
                if (lap_ok) begin
                    if (lap_active) begin
                        lap_active <= 1'b0;
                    end else if (state == ST_RUN) begin
                        lap_active <= 1'b1;
                        snapshot   <= live;
                    end
                end
                digits_out <= lap_active ? snapshot : live;
            end
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= finish;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_engine.sv
// Scoreboard bench for stopwatch_engine: an integer-count reference model
// predicts every cycle's outputs, a negedge monitor pops and compares them.
module tb_stopwatch_engine;

    localparam int          CLK_HZ  = 10;
    localparam int          TICK_HZ = 1;
    localparam int          N       = 4;
    localparam logic [31:0] BASES   = 32'h0000_6A6A;
    localparam int          P       = CLK_HZ / TICK_HZ;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;
    typedef struct packed {
        logic [15:0] disp;
        logic        run;
        logic        lap;
        logic        ovf;
        logic        tck;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] digits_out;
    logic        running, lap_active, overflow, tick;
`ifdef STOPWATCH_COUNTDOWN_EN
    logic        count_down = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        done;
`endif

    stopwatch_engine #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TICK_FREQ_HZ(TICK_HZ),
        .NUM_DIGITS  (N),
        .DIGIT_BASES (BASES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
`ifdef STOPWATCH_COUNTDOWN_EN
        .count_down(count_down),
        .load      (load),
        .load_value(load_value),
        .done      (done),
`endif
        .digits_out(digits_out),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    obs_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: elapsed ticks as one integer, converted to digits on demand.
    int    base[N];
    int    max_count;
    mode_t m_mode;
    int    m_phase, m_count, m_snap;
    bit    m_ovf, m_lap;
    logic [15:0] m_disp;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(v % base[i]);
            v = v / base[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_count = 0; m_snap = 0;
        m_ovf = 0; m_lap = 0; m_disp = '0;
    endtask

    task automatic model_step(input bit ss, input bit clr, input bit lp);
        obs_t e;
        bit   t;
        int   old;
        t = (m_mode == M_RUN) && (m_phase == P - 1) && !clr;
        e.disp = m_disp; e.run = (m_mode == M_RUN); e.lap = m_lap; e.ovf = m_ovf; e.tck = t;
        exp_q.push_back(e);
        if (clr) begin
            model_reset();
        end else begin
            old = m_count;
            m_disp = m_lap ? to_bcd(m_snap) : to_bcd(m_count);
            if (m_mode == M_RUN) m_phase = (m_phase + 1) % P;
            if (t) begin
                m_count++;
                if (m_count == max_count) begin
                    m_count = 0;
                    m_ovf = 1;
                end
            end
            if (ss) begin
                m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end else if (lp) begin
                if (m_lap) m_lap = 0;
                else if (m_mode == M_RUN) begin
                    m_lap = 1;
                    m_snap = old;
                end
            end
        end
    endtask

    task automatic cycle(input bit ss, input bit clr, input bit lp);
        @(posedge clk);
        #2;
        start_stop = ss; clear = clr; lap = lp;
        model_step(ss, clr, lp);
    endtask

    task automatic run(input int n);
        repeat (n) cycle(0, 0, 0);
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {12'h0, digits_out, running, lap_active, overflow, tick}, {12'h0, e});
        end
    end

    initial begin
        max_count = 1;
        for (int i = 0; i < N; i++) begin
            base[i] = int'(BASES[i*4 +: 4]);
            max_count = max_count * base[i];
        end
        model_reset();

        #1 rst_n = 1'b0;
        #2 check("reset_outputs", {digits_out, running, lap_active, overflow, tick}, 20'h0);
        #9 rst_n = 1'b1;

        // Long run: 10:00 after 600 ticks, wrap plus overflow after 3600.
        cycle(1, 0, 0);
        run(6003);
        @(negedge clk); #1;
        check("after_600_ticks", {digits_out, running, overflow}, {16'h1000, 1'b1, 1'b0});
        run(30000);
        @(negedge clk); #1;
        check("after_3600_ticks", {digits_out, running, overflow}, {16'h0000, 1'b1, 1'b1});
        cycle(0, 1, 0);
        run(1);
        @(negedge clk); #1;
        check("clear_overflow", {overflow, running}, 2'b00);

        // Pause with a partial prescaler period, then resume.
        cycle(1, 0, 0);
        run(122);
        @(negedge clk); #1;
        check("reach_0012", digits_out, 16'h0012);
        cycle(1, 0, 0);
        run(100);
        @(negedge clk); #1;
        check("paused_hold", {digits_out, running, tick}, {16'h0012, 1'b0, 1'b0});
        cycle(1, 0, 0);
        run(6);
        @(negedge clk); #1;
        check("resume_no_tick_yet", tick, 1'b0);
        run(1);
        @(negedge clk); #1;
        check("resume_tick_7clk", tick, 1'b1);

        // Lap freeze for 30 ticks, then release.
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        run(121);
        cycle(0, 0, 1);
        run(278);
        @(negedge clk); #1;
        check("lap_frozen", {digits_out, lap_active}, {16'h0012, 1'b1});
        run(24);
        cycle(0, 0, 1);
        run(2);
        @(negedge clk); #1;
        check("lap_release", {digits_out, lap_active}, {16'h0042, 1'b0});

        // Clear beats a coincident start_stop while running.
        cycle(1, 1, 0);
        run(1);
        @(negedge clk); #1;
        check("clear_vs_start", {digits_out, running}, {16'h0000, 1'b0});

        // Asynchronous reset mid-count.
        cycle(1, 0, 0);
        run(57);
        @(posedge clk);
        #2 rst_n = 1'b0;
        start_stop = 0; clear = 0; lap = 0;
        #1 check("async_reset", {digits_out, running, lap_active, overflow, tick}, 20'h0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomised pulses, including coincident ones.
        cycle(1, 0, 0);
        repeat (3000) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 29) == 0);
        end
        run(3);
        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);

`ifdef STOPWATCH_COUNTDOWN_EN
        begin : countdown
            int  waited;
            bit  seen;
            @(posedge clk); #2 start_stop = 0; clear = 1; lap = 0;
            @(posedge clk); #2 clear = 0; load = 1; load_value = 16'h0002; count_down = 1;
            @(posedge clk); #2 load = 0; start_stop = 1;
            @(posedge clk); #2 start_stop = 0;
            repeat (14) @(posedge clk);
            @(negedge clk); check("down_0001", digits_out, 16'h0001);
            repeat (10) @(posedge clk);
            @(negedge clk); check("down_0000", {digits_out, running}, {16'h0000, 1'b1});
            seen = 0;
            waited = 0;
            while (!seen && waited < 20) begin
                @(negedge clk);
                seen = done;
                waited++;
            end
            check("done_pulse", seen, 1'b1);
            check("done_idle", {digits_out, running}, {16'h0000, 1'b0});
            @(posedge clk); #2 load = 1; load_value = 16'h00F9;
            @(posedge clk); #2 load = 0;
            @(posedge clk);
            @(negedge clk); check("load_clamp", digits_out, 16'h0059);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
